// File: rtl/regfile_seq_pkg.sv
// Shared definitions for the register-file sequencer: opcode and FSM state encodings.
package regfile_seq_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4,
      OP_MOV = 3'd5,
      OP_SHL = 3'd6,
      OP_SHR = 3'd7
   } op_e;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      READ_A = 3'd1,
      READ_B = 3'd2,
      EXEC   = 3'd3,
      WRITE  = 3'd4
   } state_e;

endpackage

// File: rtl/regfile_seq_alu.sv
// Combinational ALU for the sequencer: computes result, carry/borrow and zero flag.
module regfile_seq_alu
   import regfile_seq_pkg::*;
#(
   parameter int DW = 16
) (
   input  op_e           op,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic [DW-1:0] result,
   output logic          carry,
   output logic          zero
);

   logic [DW:0] sum;
   logic [DW:0] diff;

   // Select the operation; the extra top bit of sum/diff carries out the carry or borrow
   always_comb begin
      sum    = {1'b0, a} + {1'b0, b};
      diff   = {1'b0, a} - {1'b0, b};
      result = '0;
      carry  = 1'b0;
      case (op)
         OP_ADD: begin
            result = sum[DW-1:0];
            carry  = sum[DW];
         end
         OP_SUB: begin
            result = diff[DW-1:0];
            carry  = diff[DW];
         end
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_XOR: result = a ^ b;
         OP_MOV: result = a;
         OP_SHL: begin
            result = {a[DW-2:0], 1'b0};
            carry  = a[DW-1];
         end
         OP_SHR: begin
            result = {1'b0, a[DW-1:1]};
            carry  = a[0];
         end
         default: begin
            result = '0;
            carry  = 1'b0;
         end
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/regfile_sequencer.sv
// Multi-cycle sequencer: fetches two operands from an external register file,
// runs them through the ALU and writes the result back, one instruction at a time.
module regfile_sequencer
   import regfile_seq_pkg::*;
#(
   parameter int AW = 2,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [2:0]    in_op,
   input  logic [AW-1:0] in_rd,
   input  logic [AW-1:0] in_rs1,
   input  logic [AW-1:0] in_rs2,
   output logic [AW-1:0] rf_r_address,
   input  logic [DW-1:0] rf_r_data,
   output logic          rf_w_enable,
   output logic [AW-1:0] rf_w_address,
   output logic [DW-1:0] rf_w_data,
   output logic          done,
   output logic          carry,
   output logic          zero
);

   state_e        state;
   op_e           op_q;
   logic [AW-1:0] rd_q;
   logic [AW-1:0] rs1_q;
   logic [AW-1:0] rs2_q;
   logic [DW-1:0] opa;
   logic [DW-1:0] opb;
   logic [DW-1:0] result_q;

   logic [DW-1:0] alu_result;
   logic          alu_carry;
   logic          alu_zero;

   regfile_seq_alu #(
      .DW(DW)
   ) u_alu (
      .op     (op_q),
      .a      (opa),
      .b      (opb),
      .result (alu_result),
      .carry  (alu_carry),
      .zero   (alu_zero)
   );

   // FSM plus datapath registers; flags are loaded in EXEC so they show during WRITE
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         op_q     <= OP_ADD;
         rd_q     <= '0;
         rs1_q    <= '0;
         rs2_q    <= '0;
         opa      <= '0;
         opb      <= '0;
         result_q <= '0;
         carry    <= 1'b0;
         zero     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  op_q  <= op_e'(in_op);
                  rd_q  <= in_rd;
                  rs1_q <= in_rs1;
                  rs2_q <= in_rs2;
                  state <= READ_A;
               end
            end
            READ_A: begin
               opa   <= rf_r_data;
               state <= READ_B;
            end
            READ_B: begin
               opb   <= rf_r_data;
               state <= EXEC;
            end
            EXEC: begin
               result_q <= alu_result;
               carry    <= alu_carry;
               zero     <= alu_zero;
               state    <= WRITE;
            end
            WRITE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Read port points at the source being fetched and rests at 0 otherwise
   always_comb begin
      rf_r_address = '0;
      case (state)
         READ_A:  rf_r_address = rs1_q;
         READ_B:  rf_r_address = rs2_q;
         default: rf_r_address = '0;
      endcase
   end

   assign in_ready     = (state == IDLE);
   assign rf_w_enable  = (state == WRITE);
   assign done         = (state == WRITE);
   assign rf_w_address = rd_q;
   assign rf_w_data    = result_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Scoreboard bench for regfile_sequencer: directed instructions against a
// behavioural 4x16 register file, with expected write-backs checked on done.
module tb_regfile_sequencer;

   typedef struct {
      logic [1:0]  addr;
      logic [15:0] data;
      logic        c;
      logic        z;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_op;
   logic [1:0]  in_rd;
   logic [1:0]  in_rs1;
   logic [1:0]  in_rs2;
   logic [1:0]  rf_r_address;
   logic [15:0] rf_r_data;
   logic        rf_w_enable;
   logic [1:0]  rf_w_address;
   logic [15:0] rf_w_data;
   logic        done;
   logic        carry;
   logic        zero;

   logic        load_en;
   logic [1:0]  load_addr;
   logic [15:0] load_data;
   logic [15:0] rf [4];

   exp_t exp_q[$];
   int   acc_q[$];
   int   cyc       = 0;
   int   acc_count = 0;
   int   check_count = 0;
   int   pass_count  = 0;

   regfile_sequencer #(
      .AW(2),
      .DW(16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_op        (in_op),
      .in_rd        (in_rd),
      .in_rs1       (in_rs1),
      .in_rs2       (in_rs2),
      .rf_r_address (rf_r_address),
      .rf_r_data    (rf_r_data),
      .rf_w_enable  (rf_w_enable),
      .rf_w_address (rf_w_address),
      .rf_w_data    (rf_w_data),
      .done         (done),
      .carry        (carry),
      .zero         (zero)
   );

   always #5 clk = ~clk;

   assign rf_r_data = rf[rf_r_address];

   // Register-file model: bench preloads take priority over DUT writes
   always @(posedge clk) begin
      if (load_en) rf[load_addr] <= load_data;
      else if (rf_w_enable) rf[rf_w_address] <= rf_w_data;
   end

   // Cycle counter and handshake log; a reset throws away in-flight acceptances
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst) begin
         acc_q.delete();
      end else if (in_valid && in_ready) begin
         acc_q.push_back(cyc + 1);
         acc_count <= acc_count + 1;
      end
   end

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      check_count++;
      if (actual === expected) pass_count++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   // Monitor: on every done pulse pop the oldest expectation and compare the write-back
   always @(negedge clk) begin
      exp_t e;
      int   a;
      if (rst) begin
         check_output("w_enable_matches_done", {31'd0, rf_w_enable}, {31'd0, done});
         if (done) begin
            if (exp_q.size() == 0) begin
               check_count++;
               $display("[TB] FAIL unexpected_done: got done with 0 pending, expected none");
            end else begin
               e = exp_q.pop_front();
               check_output("w_address", {30'd0, rf_w_address}, {30'd0, e.addr});
               check_output("w_data", {16'd0, rf_w_data}, {16'd0, e.data});
               check_output("carry", {31'd0, carry}, {31'd0, e.c});
               check_output("zero", {31'd0, zero}, {31'd0, e.z});
            end
            if (acc_q.size() == 0) begin
               check_count++;
               $display("[TB] FAIL done_latency: got done with no accepted instruction, expected one");
            end else begin
               a = acc_q.pop_front();
               check_output("done_latency", cyc, a + 3);
            end
         end
      end
   end

   task automatic apply_stimulus(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                                 input logic [1:0] rs2, input logic [15:0] exp_data,
                                 input logic exp_c, input logic exp_z, input bit push);
      int   waited = 0;
      exp_t e;
      while (!in_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         check_count++;
         $display("[TB] FAIL handshake_timeout: got in_ready 0, expected 1");
      end
      in_valid = 1'b1;
      in_op    = op;
      in_rd    = rd;
      in_rs1   = rs1;
      in_rs2   = rs2;
      if (push) begin
         e.addr = rd;
         e.data = exp_data;
         e.c    = exp_c;
         e.z    = exp_z;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic load_register(input logic [1:0] addr, input logic [15:0] data);
      load_en   = 1'b1;
      load_addr = addr;
      load_data = data;
      @(posedge clk);
      #1 load_en = 1'b0;
   endtask

   task automatic drain();
      int waited = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || !in_ready) && waited < 60) begin
         @(negedge clk);
         waited++;
      end
      if (exp_q.size() != 0 || !in_ready) begin
         check_count++;
         $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
      end
   endtask

   // Directed scenarios; expected write-backs are hand-computed constants
   initial begin
      int acc0;
      logic [31:0] exp_ready;
      logic [31:0] exp_addr;

      rst       = 1'b0;
      in_valid  = 1'b0;
      in_op     = 3'd0;
      in_rd     = 2'd0;
      in_rs1    = 2'd0;
      in_rs2    = 2'd0;
      load_en   = 1'b0;
      load_addr = 2'd0;
      load_data = 16'd0;

      #3;
      check_output("reset_in_ready", {31'd0, in_ready}, 32'd1);
      check_output("reset_done", {31'd0, done}, 32'd0);
      check_output("reset_w_enable", {31'd0, rf_w_enable}, 32'd0);
      check_output("reset_carry", {31'd0, carry}, 32'd0);
      check_output("reset_zero", {31'd0, zero}, 32'd0);
      check_output("reset_r_address", {30'd0, rf_r_address}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // Scenario 1: 3 + 5
      load_register(2'd1, 16'h0003);
      load_register(2'd2, 16'h0005);
      apply_stimulus(3'd0, 2'd3, 2'd1, 2'd2, 16'h0008, 1'b0, 1'b0, 1'b1);
      drain();

      // Scenario 2: wraparound add sets carry and zero
      load_register(2'd1, 16'hFFFF);
      load_register(2'd2, 16'h0001);
      apply_stimulus(3'd0, 2'd0, 2'd1, 2'd2, 16'h0000, 1'b1, 1'b1, 1'b1);
      drain();

      // Scenario 5: reset during READ_B aborts the instruction
      load_register(2'd1, 16'h0007);
      load_register(2'd2, 16'h0009);
      apply_stimulus(3'd0, 2'd0, 2'd1, 2'd2, 16'h0000, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check_output("abort_in_ready", {31'd0, in_ready}, 32'd1);
      check_output("abort_done", {31'd0, done}, 32'd0);
      check_output("abort_w_enable", {31'd0, rf_w_enable}, 32'd0);
      check_output("abort_carry", {31'd0, carry}, 32'd0);
      check_output("abort_zero", {31'd0, zero}, 32'd0);
      check_output("abort_r_address", {30'd0, rf_r_address}, 32'd0);
      repeat (2) @(negedge clk);
      check_output("abort_no_write_r0", {16'd0, rf[0]}, 32'h0000);
      #1 rst = 1'b1;
      apply_stimulus(3'd0, 2'd0, 2'd1, 2'd2, 16'h0010, 1'b0, 1'b0, 1'b1);
      drain();

      // Scenario 3: SUB with borrow, then SHR of the written result
      load_register(2'd1, 16'h0002);
      load_register(2'd2, 16'h0005);
      apply_stimulus(3'd1, 2'd1, 2'd1, 2'd2, 16'hFFFD, 1'b1, 1'b0, 1'b1);
      apply_stimulus(3'd7, 2'd1, 2'd1, 2'd0, 16'h7FFE, 1'b1, 1'b0, 1'b1);
      drain();

      // Scenario 6: XOR of a register with itself into the same register
      load_register(2'd2, 16'hA5A5);
      apply_stimulus(3'd4, 2'd2, 2'd2, 2'd2, 16'h0000, 1'b0, 1'b1, 1'b1);
      drain();
      check_output("s6_r2_cleared", {16'd0, rf[2]}, 32'h0000);

      // Remaining ops: SHL carry-out, logic ops, MOV, equal-operand SUB
      load_register(2'd1, 16'h8001);
      apply_stimulus(3'd6, 2'd3, 2'd1, 2'd0, 16'h0002, 1'b1, 1'b0, 1'b1);
      drain();
      load_register(2'd1, 16'hF0F0);
      load_register(2'd2, 16'h0FF0);
      apply_stimulus(3'd2, 2'd3, 2'd1, 2'd2, 16'h00F0, 1'b0, 1'b0, 1'b1);
      apply_stimulus(3'd3, 2'd3, 2'd1, 2'd2, 16'hFFF0, 1'b0, 1'b0, 1'b1);
      apply_stimulus(3'd5, 2'd0, 2'd1, 2'd2, 16'hF0F0, 1'b0, 1'b0, 1'b1);
      drain();
      load_register(2'd1, 16'h1234);
      load_register(2'd2, 16'h1234);
      apply_stimulus(3'd1, 2'd3, 2'd1, 2'd2, 16'h0000, 1'b0, 1'b1, 1'b1);
      drain();

      // Scenario 4: in_valid held for 12 edges accepts exactly 3 MOVs
      load_register(2'd1, 16'h1111);
      for (int k = 0; k < 3; k++) exp_q.push_back('{addr: 2'd3, data: 16'h1111, c: 1'b0, z: 1'b0});
      acc0     = acc_count;
      in_valid = 1'b1;
      in_op    = 3'd5;
      in_rd    = 2'd3;
      in_rs1   = 2'd1;
      in_rs2   = 2'd2;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk);
         @(negedge clk);
         exp_ready = (i % 5 == 0) ? 32'd1 : 32'd0;
         exp_addr  = (i % 5 == 1) ? 32'd1 : ((i % 5 == 2) ? 32'd2 : 32'd0);
         check_output("s4_in_ready", {31'd0, in_ready}, exp_ready);
         check_output("s4_r_address", {30'd0, rf_r_address}, exp_addr);
      end
      in_valid = 1'b0;
      check_output("s4_accept_count", acc_count - acc0, 32'd3);
      drain();
      check_output("s4_r3_final", {16'd0, rf[3]}, 32'h1111);

      check_output("scoreboard_empty", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule

// File: doc/regfile_sequencer.md
REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

Interface
REQ-001 Parameter AW, default 2: register-file address width; 2**AW registers.
REQ-002 Parameter DW, default 16: data word width.
REQ-003 clk  in  1: single clock; all state updates on posedge clk.
REQ-004 rst  in  1: reset, asynchronous, active-low.
REQ-005 in_valid  in  1: instruction offered.
REQ-006 in_ready  out  1: sequencer can accept an instruction.
REQ-007 in_op  in  3: opcode, captured when in_valid and in_ready are both 1.
REQ-008 in_rd, in_rs1, in_rs2  in  AW each: destination and source register addresses.
REQ-009 rf_r_address  out  AW: register-file read address.
REQ-010 rf_r_data  in  DW: register-file read data, combinational from rf_r_address.
REQ-011 rf_w_enable  out  1: register-file write strobe.
REQ-012 rf_w_address  out  AW: register-file write address.
REQ-013 rf_w_data  out  DW: register-file write data.
REQ-014 done  out  1: one-cycle pulse marking instruction completion.
REQ-015 carry, zero  out  1 each: flags of the last completed instruction.

Function
REQ-016 FSM states: IDLE, READ_A, READ_B, EXEC, WRITE.
REQ-017 IDLE: in_ready=1; on in_valid, capture op/rd/rs1/rs2 and go to READ_A; otherwise stay in IDLE.
REQ-018 in_ready shall be 0 in every state other than IDLE; in_valid outside IDLE is ignored.
REQ-019 READ_A: rf_r_address=rs1; latch rf_r_data into operand A at the cycle end; go to READ_B.
REQ-020 READ_B: rf_r_address=rs2; latch rf_r_data into operand B; go to EXEC.
REQ-021 EXEC: compute the result and flags into registers; go to WRITE.
REQ-022 WRITE: rf_w_enable=1, rf_w_address=rd, rf_w_data=result, done=1, carry/zero updated; go to IDLE.
REQ-023 Latency: handshake edge N -> rf_w_enable and done high during cycle N+4; next accept no earlier than edge N+5.
REQ-024 Ops: 0 ADD A+B, 1 SUB A-B, 2 AND, 3 OR, 4 XOR, 5 MOV (A), 6 SHL A<<1, 7 SHR A>>1 (logical).
REQ-025 Arithmetic is modulo 2**DW; ADD carry = bit DW of the (DW+1)-bit sum; SUB carry = borrow (A<B unsigned).
REQ-026 SHL carry = A[DW-1]; SHR carry = A[0]; logic ops and MOV clear carry.
REQ-027 zero = 1 exactly when the DW-bit result is 0.
REQ-028 rs1=rs2 and rd equal to a source are legal; rd equal to a source is overwritten only at the WRITE edge.
REQ-029 rf_r_address shall be 0 in IDLE, EXEC and WRITE.
REQ-030 rf_w_enable shall be 0 outside WRITE; rf_w_address and rf_w_data are don't-care while it is 0.

Reset
REQ-031 rst low shall immediately force: state IDLE, in_ready=1, rf_w_enable=0, done=0, carry=0, zero=0, operands and result 0.
REQ-032 Reset mid-instruction aborts it with no register-file write; after rst rises, the first posedge accepts a new instruction.

Structure
REQ-033 Shared package regfile_seq_pkg holds the opcode enum (OP_ADD..OP_SHR) and the state enum.
REQ-034 Sub-module regfile_seq_alu: combinational; inputs op, A and B; outputs result, carry and zero; instantiated once and registered in EXEC.
REQ-035 Target size: 120-400 lines of RTL; no memories inside the block.

Verification
REQ-036 Run each scenario against a behavioural 4x16 register-file model.
REQ-037 Scenario 1: R1=0x0003, R2=0x0005, ADD rd=3 -> R3=0x0008, carry=0, zero=0, done at cycle N+4.
REQ-038 Scenario 2: R1=0xFFFF, R2=0x0001, ADD rd=0 -> R0=0x0000, carry=1, zero=1.
REQ-039 Scenario 3: R1=0x0002, R2=0x0005, SUB rd=1 -> R1=0xFFFD, carry=1; then SHR of R1 -> 0x7FFE, carry=1.
REQ-040 Scenario 4: in_valid held high for 12 cycles -> exactly 3 instructions accepted (edges N, N+5, N+10), in_ready high only in IDLE.
REQ-041 Scenario 5: rst low during READ_B -> no write occurs, done=0, in_ready=1 immediately; next instruction completes normally.
REQ-042 Scenario 6: XOR rs1=rs2=2 with R2=0xA5A5, rd=2 -> R2=0x0000, zero=1, carry=0.
